// File: rtl/muldiv_ctrl_if.sv
// Handshake and HI/LO write-port bundle between the EX stage and muldiv_ctrl.
// MULDIV_DIV0_FLAG_EN adds the div0 status line.
interface muldiv_ctrl_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic             hi_w;
    logic [WIDTH-1:0] hi_in;
    logic             lo_w;
    logic [WIDTH-1:0] lo_in;
`ifdef MULDIV_DIV0_FLAG_EN
    logic             div0;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi_w, hi_in, lo_w, lo_in, div0
    );
    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi_w, hi_in, lo_w, lo_in, div0
    );
`else
    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi_w, hi_in, lo_w, lo_in
    );
    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi_w, hi_in, lo_w, lo_in
    );
`endif
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer and sole writer of HI/LO (incl. MTHI/MTLO).
// Define MULDIV_DIV0_FLAG_EN to expose a divide-by-zero flag that pulses with done.
module muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input logic           clk,
    input logic           rst_n,
    muldiv_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StWb
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // MUL: {hi, lo}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]     opd_q, opd_d;     // |a| for MUL, |b| for DIV
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 hi_w_q, hi_w_d;
    logic                 lo_w_q, lo_w_d;
    logic [WIDTH-1:0]     hi_in_q, hi_in_d;
    logic [WIDTH-1:0]     lo_in_q, lo_in_d;
    logic                 flag_q, flag_d;

    logic                 op_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;

    always_comb begin
        op_signed = ~bus.op[0];
        a_neg     = op_signed & bus.a[WIDTH-1];
        b_neg     = op_signed & bus.b[WIDTH-1];
        abs_a     = a_neg ? -bus.a : bus.a;
        abs_b     = b_neg ? -bus.b : bus.b;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opd_q};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        hi_w_d   = 1'b0;
        lo_w_d   = 1'b0;
        hi_in_d  = hi_in_q;
        lo_in_d  = lo_in_q;
        flag_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // busy_q is still high during the done cycle; nothing is accepted then
                if (!busy_q) begin
                    if (bus.start) begin
                        is_div_d = bus.op[1];
                        neg_d    = a_neg ^ b_neg;
                        rneg_d   = a_neg;
                        dz_d     = (bus.b == '0);
                        cnt_d    = '0;
                        if (bus.op[1]) begin
                            opd_d   = abs_b;
                            acc_d   = {{WIDTH{1'b0}}, abs_a};
                            state_d = StDiv;
                        end else begin
                            opd_d   = abs_a;
                            acc_d   = {{WIDTH{1'b0}}, abs_b};
                            state_d = StMul;
                        end
                    end else begin
                        if (bus.mthi) begin
                            hi_w_d  = 1'b1;
                            hi_in_d = bus.a;
                        end
                        if (bus.mtlo) begin
                            lo_w_d  = 1'b1;
                            lo_in_d = bus.a;
                        end
                    end
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StDiv: begin
                if (!div_diff[WIDTH]) begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!is_div_q) begin
                    if (neg_q) begin
                        acc_d = -acc_q;
                    end
                end else begin
                    if (neg_q && !dz_q) begin
                        acc_d[WIDTH-1:0] = -acc_q[WIDTH-1:0];
                    end
                    // On b==0 the remainder is |a|, so this negation restores the raw a
                    if (rneg_q) begin
                        acc_d[2*WIDTH-1:WIDTH] = -acc_q[2*WIDTH-1:WIDTH];
                    end
                end
                state_d = StWb;
            end
            StWb: begin
                done_d  = 1'b1;
                hi_w_d  = 1'b1;
                lo_w_d  = 1'b1;
                hi_in_d = acc_q[2*WIDTH-1:WIDTH];
                lo_in_d = acc_q[WIDTH-1:0];
                flag_d  = is_div_q & dz_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle) || done_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_w_q   <= 1'b0;
            lo_w_q   <= 1'b0;
            hi_in_q  <= '0;
            lo_in_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_w_q   <= hi_w_d;
            lo_w_q   <= lo_w_d;
            hi_in_q  <= hi_in_d;
            lo_in_q  <= lo_in_d;
            flag_q   <= flag_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.hi_w  = hi_w_q;
    assign bus.lo_w  = lo_w_q;
    assign bus.hi_in = hi_in_q;
    assign bus.lo_in = lo_in_q;

`ifdef MULDIV_DIV0_FLAG_EN
    assign bus.div0 = flag_q;
`else
    logic unused_flag;
    assign unused_flag = flag_q;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: transaction-level timeline model checked every cycle,
// plus directed operations with hand-computed HI/LO results.
module tb_muldiv_ctrl;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_ctrl_if #(.WIDTH(W)) bus ();

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Architectural result of one operation, straight from the arithmetic definition
    function automatic void model_op(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] hi,
                                     output logic [31:0] lo, output logic dz);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sa = a;
        sb = b;
        dz = op[1] && (b == 32'd0);
        case (op)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                hi = sp[63:32];
                lo = sp[31:0];
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    hi = 32'd0;
                    lo = 32'h8000_0000;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Timeline model: an accepted start writes back W+2 edges later, busy clears one edge after
    bit          model_valid = 1'b0;
    bit          pending = 1'b0;
    int          edge_cnt = 0;
    int          t_wb = 0;
    logic        exp_busy, exp_done, exp_hw, exp_lw, exp_rst, exp_div0;
    logic [31:0] exp_hi, exp_lo, res_hi, res_lo;
    logic        res_dz;

    always @(posedge clk) begin
        model_valid = 1'b1;
        exp_rst  = 1'b0;
        exp_done = 1'b0;
        exp_hw   = 1'b0;
        exp_lw   = 1'b0;
        exp_div0 = 1'b0;
        if (!rst_n) begin
            pending  = 1'b0;
            exp_busy = 1'b0;
            exp_hi   = 32'd0;
            exp_lo   = 32'd0;
            exp_rst  = 1'b1;
        end else if (pending) begin
            if (edge_cnt == t_wb) begin
                exp_done = 1'b1;
                exp_hw   = 1'b1;
                exp_lw   = 1'b1;
                exp_hi   = res_hi;
                exp_lo   = res_lo;
                exp_div0 = res_dz;
            end else if (edge_cnt == t_wb + 1) begin
                pending  = 1'b0;
                exp_busy = 1'b0;
            end
        end else if (bus.start) begin
            pending  = 1'b1;
            exp_busy = 1'b1;
            t_wb     = edge_cnt + W + 2;
            model_op(bus.op, bus.a, bus.b, res_hi, res_lo, res_dz);
        end else begin
            if (bus.mthi) begin
                exp_hw = 1'b1;
                exp_hi = bus.a;
            end
            if (bus.mtlo) begin
                exp_lw = 1'b1;
                exp_lo = bus.a;
            end
        end
        edge_cnt++;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
            chk("done", {31'd0, bus.done}, {31'd0, exp_done});
            chk("hi_w", {31'd0, bus.hi_w}, {31'd0, exp_hw});
            chk("lo_w", {31'd0, bus.lo_w}, {31'd0, exp_lw});
            if (exp_hw || exp_rst) chk("hi_in", bus.hi_in, exp_hi);
            if (exp_lw || exp_rst) chk("lo_in", bus.lo_in, exp_lo);
`ifdef MULDIV_DIV0_FLAG_EN
            chk("div0", {31'd0, bus.div0}, {31'd0, exp_div0});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges after the start edge at which done was seen
    task automatic wait_done(input string name, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic mv_lo,
                          input logic [31:0] want_hi, input logic [31:0] want_lo);
        int n;
        tick();
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.mtlo  = mv_lo;
        tick();
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
        wait_done(name, n);
        chk({name, "_latency"}, n, W + 2);
        chk({name, "_hi"}, bus.hi_in, want_hi);
        chk({name, "_lo"}, bus.lo_in, want_lo);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_hi_in", bus.hi_in, 32'd0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", 2'b11, 32'd100, 32'd0, 1'b0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF6, 32'd0, 1'b0, 32'hFFFF_FFF6, 32'hFFFF_FFFF);

        // Moves in idle
        tick();
        bus.mthi = 1'b1;
        bus.a    = 32'h1234_5678;
        tick();
        bus.mthi = 1'b0;
        @(negedge clk);
        chk("mthi_hw", {31'd0, bus.hi_w}, 32'd1);
        chk("mthi_data", bus.hi_in, 32'h1234_5678);
        chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        bus.a    = 32'hCAFE_F00D;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        @(negedge clk);
        chk("mtboth_hi", bus.hi_in, 32'hCAFE_F00D);
        chk("mtboth_lo", bus.lo_in, 32'hCAFE_F00D);

        // start together with mtlo: only the op runs
        run_op("start_mtlo", 2'b01, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30);

        // start and mthi while busy are ignored
        tick();
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd1000;
        bus.b     = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        tick();
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        wait_done("busy_ign", n);
        chk("busy_ign_latency", n, W + 2 - 5);
        chk("busy_ign_hi", bus.hi_in, 32'd6);
        chk("busy_ign_lo", bus.lo_in, 32'd142);
        run_op("back2back", 2'b10, 32'd50, 32'hFFFF_FFF9, 1'b0, 32'd1, 32'hFFFF_FFF9);

        // Reset in the middle of a divide
        tick();
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'h7FFF_FFFF;
        bus.b     = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        run_op("post_reset", 2'b01, 32'd2, 32'd3, 1'b0, 32'd0, 32'd6);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
